// File: rtl/mw_eeprom_responder.sv
// Device-side model of a 93xx-family Microwire serial EEPROM, x16 organisation.
// Decodes start/opcode/address frames on cs/sk/di, streams READ data on do_out
// and runs WRITE/ERASE/ERAL/WRAL programming cycles with a busy/ready status.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | deselected, waiting for cs high
// START   | selected, waiting for a start bit (di=1 on sk rise)
// OPC     | shifting the 2 opcode bits
// ADDR    | shifting ADDR_W address bits, MSB first
// DIN     | shifting DATA_W write data bits (WRITE / WRAL)
// DOUT    | streaming read data, auto-incrementing address
// COMMIT  | frame complete, waiting for cs fall (ERASE / ERAL / EWEN / EWDS)
// PROG    | programming cycle running, busy=1
// STATUS  | programming finished, ready shown on do_out while cs high
module mw_eeprom_responder #(
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 16,
   parameter int PROG_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic cs,
   input  logic sk,
   input  logic di,
   output logic do_out,
   output logic do_oe,
   output logic busy
);

   localparam int WORDS = 2 ** ADDR_W;
   localparam int CNT_W = $clog2(DATA_W + ADDR_W + 1);
   localparam int TMR_W = $clog2(PROG_CYCLES + 1);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_START  = 4'd1;
   localparam logic [3:0] S_OPC    = 4'd2;
   localparam logic [3:0] S_ADDR   = 4'd3;
   localparam logic [3:0] S_DIN    = 4'd4;
   localparam logic [3:0] S_DOUT   = 4'd5;
   localparam logic [3:0] S_COMMIT = 4'd6;
   localparam logic [3:0] S_PROG   = 4'd7;
   localparam logic [3:0] S_STATUS = 4'd8;

   localparam logic [2:0] C_NOP   = 3'd0;
   localparam logic [2:0] C_WRITE = 3'd1;
   localparam logic [2:0] C_ERASE = 3'd2;
   localparam logic [2:0] C_ERAL  = 3'd3;
   localparam logic [2:0] C_WRAL  = 3'd4;

   logic              cs_meta_q, cs_s_q;
   logic              sk_meta_q, sk_s_q, sk_prev_q;
   logic              di_meta_q, di_s_q;
   logic              sk_rise;

   logic [3:0]        state_q, state_d;
   logic [1:0]        opc_q, opc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        cmd_q, cmd_d;
   logic              wen_q, wen_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              do_out_q, do_out_d;
   logic              do_oe_q, do_oe_d;

   logic [DATA_W-1:0] mem_q [WORDS];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic [ADDR_W-1:0] addr_shift;
   logic [ADDR_W-1:0] addr_next;
   logic              din_full;
   logic              multi;
   logic              fill_ones;

   assign sk_rise   = sk_s_q & ~sk_prev_q;
   assign addr_shift = {addr_q[ADDR_W-2:0], di_s_q};
   assign addr_next = addr_q + ADDR_W'(1);
   assign din_full  = (cnt_q == CNT_W'(DATA_W));
   assign multi     = (cmd_q == C_ERAL) || (cmd_q == C_WRAL);
   assign fill_ones = (cmd_q == C_ERASE) || (cmd_q == C_ERAL);

   assign do_out = do_out_q;
   assign do_oe  = do_oe_q;
   assign busy   = (state_q == S_PROG);

   // Two-flop synchronisers on the serial pins plus the sk edge history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_meta_q <= 1'b0;
         cs_s_q    <= 1'b0;
         sk_meta_q <= 1'b0;
         sk_s_q    <= 1'b0;
         sk_prev_q <= 1'b0;
         di_meta_q <= 1'b0;
         di_s_q    <= 1'b0;
      end else begin
         cs_meta_q <= cs;
         cs_s_q    <= cs_meta_q;
         sk_meta_q <= sk;
         sk_s_q    <= sk_meta_q;
         sk_prev_q <= sk_s_q;
         di_meta_q <= di;
         di_s_q    <= di_meta_q;
      end
   end

   // Next-state logic: frame decode, data streaming and the programming timer.
   always_comb begin
      state_d   = state_q;
      opc_d     = opc_q;
      addr_d    = addr_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      cmd_d     = cmd_q;
      wen_d     = wen_q;
      timer_d   = timer_q;
      do_out_d  = do_out_q;
      do_oe_d   = do_oe_q;
      mem_we    = 1'b0;
      mem_waddr = addr_q;
      mem_wdata = fill_ones ? '1 : shreg_q;

      // Deselect is checked before any sk edge so a coincident edge is dropped.
      if (state_q != S_PROG && !cs_s_q) begin
         state_d  = S_IDLE;
         do_oe_d  = 1'b0;
         do_out_d = 1'b0;
         if (wen_q && ((state_q == S_DIN && din_full) ||
                       (state_q == S_COMMIT && fill_ones))) begin
            state_d = S_PROG;
            timer_d = TMR_W'(PROG_CYCLES - 1);
            if (multi) begin
               addr_d = '0;
            end
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               do_oe_d = 1'b0;
               state_d = S_START;
            end
            S_START: begin
               if (sk_rise && di_s_q) begin
                  state_d = S_OPC;
                  cnt_d   = '0;
               end
            end
            S_OPC: begin
               if (sk_rise) begin
                  opc_d = {opc_q[0], di_s_q};
                  if (cnt_q == CNT_W'(1)) begin
                     state_d = S_ADDR;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            S_ADDR: begin
               if (sk_rise) begin
                  addr_d = addr_shift;
                  if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                     cnt_d = '0;
                     case (opc_q)
                        2'b10: begin
                           state_d  = S_DOUT;
                           shreg_d  = mem_q[addr_shift];
                           do_oe_d  = 1'b1;
                           do_out_d = 1'b0;
                        end
                        2'b01: begin
                           state_d = S_DIN;
                           cmd_d   = C_WRITE;
                        end
                        2'b11: begin
                           state_d = S_COMMIT;
                           cmd_d   = C_ERASE;
                        end
                        default: begin
                           case (addr_shift[ADDR_W-1 -: 2])
                              2'b11: begin
                                 wen_d   = 1'b1;
                                 cmd_d   = C_NOP;
                                 state_d = S_COMMIT;
                              end
                              2'b00: begin
                                 wen_d   = 1'b0;
                                 cmd_d   = C_NOP;
                                 state_d = S_COMMIT;
                              end
                              2'b10: begin
                                 cmd_d   = C_ERAL;
                                 state_d = S_COMMIT;
                              end
                              default: begin
                                 cmd_d   = C_WRAL;
                                 state_d = S_DIN;
                              end
                           endcase
                        end
                     endcase
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            S_DIN: begin
               if (sk_rise && !din_full) begin
                  shreg_d = {shreg_q[DATA_W-2:0], di_s_q};
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
            S_DOUT: begin
               do_oe_d = 1'b1;
               if (sk_rise) begin
                  do_out_d = shreg_q[DATA_W-1];
                  if (cnt_q == CNT_W'(DATA_W - 1)) begin
                     // Next word is preloaded so its MSB follows with no gap bit.
                     addr_d  = addr_next;
                     shreg_d = mem_q[addr_next];
                     cnt_d   = '0;
                  end else begin
                     shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                     cnt_d   = cnt_q + CNT_W'(1);
                  end
               end
            end
            S_COMMIT: begin
               do_oe_d = 1'b0;
            end
            S_PROG: begin
               do_oe_d  = cs_s_q;
               do_out_d = 1'b0;
               if (timer_q == '0) begin
                  mem_we = 1'b1;
                  if (multi && addr_q != '1) begin
                     addr_d  = addr_next;
                     timer_d = TMR_W'(PROG_CYCLES - 1);
                  end else begin
                     state_d  = S_STATUS;
                     do_out_d = 1'b1;
                  end
               end else begin
                  timer_d = timer_q - TMR_W'(1);
               end
            end
            S_STATUS: begin
               do_oe_d  = 1'b1;
               do_out_d = 1'b1;
               if (sk_rise && di_s_q) begin
                  state_d  = S_OPC;
                  cnt_d    = '0;
                  do_oe_d  = 1'b0;
                  do_out_d = 1'b0;
               end
            end
            default: begin
               state_d = S_IDLE;
               do_oe_d = 1'b0;
            end
         endcase
      end
   end

   // Control registers; write enable comes out of reset disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         opc_q    <= '0;
         addr_q   <= '0;
         shreg_q  <= '0;
         cnt_q    <= '0;
         cmd_q    <= C_NOP;
         wen_q    <= 1'b0;
         timer_q  <= '0;
         do_out_q <= 1'b0;
         do_oe_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         opc_q    <= opc_d;
         addr_q   <= addr_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         wen_q    <= wen_d;
         timer_q  <= timer_d;
         do_out_q <= do_out_d;
         do_oe_q  <= do_oe_d;
      end
   end

   // Word array: deliberately unreset so contents survive rst like real EEPROM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

endmodule

// File: tb/tb_mw_eeprom_responder.sv
// Directed bench for mw_eeprom_responder: word-level model of the array and
// write-enable, per-cycle pin comparison in stable windows, literal pins.
module tb_mw_eeprom_responder;

   localparam int AW = 6;
   localparam int DW = 16;
   localparam int P  = 50;
   localparam int NW = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cs  = 1'b0;
   logic sk  = 1'b0;
   logic di  = 1'b0;
   logic do_out, do_oe, busy;

   logic [15:0] mm [NW];
   bit          mwen;
   logic        exp_oe   = 1'b0;
   logic        exp_out  = 1'b0;
   logic        exp_busy = 1'b0;
   bit          chk_en   = 1'b0;
   int          checks   = 0;
   int          errors   = 0;

   mw_eeprom_responder #(.ADDR_W(AW), .DATA_W(DW), .PROG_CYCLES(P)) dut (
      .clk(clk), .rst(rst), .cs(cs), .sk(sk), .di(di),
      .do_out(do_out), .do_oe(do_oe), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         checks++;
         if (do_oe !== exp_oe || busy !== exp_busy || (exp_oe && do_out !== exp_out)) begin
            errors++;
            $display("FAIL pins t=%0t got oe=%b out=%b busy=%b want oe=%b out=%b busy=%b",
                     $time, do_oe, do_out, busy, exp_oe, exp_out, exp_busy);
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_to(input logic v);
      chk_en = 0;
      cs = v;
      if (!v) exp_oe = 1'b0;
      tick(3);
      chk_en = 1;
   endtask

   task automatic bit_io(input logic b, input logic eoe, input logic eout);
      sk = 1'b0;
      di = b;
      tick(4);
      chk_en  = 0;
      sk      = 1'b1;
      exp_oe  = eoe;
      exp_out = eout;
      tick(4);
      chk_en = 1;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [5:0] a,
                           input bit from_status, input bit lead0);
      if (!from_status) cs_to(1'b1);
      if (lead0) bit_io(1'b0, 1'b0, 1'b0);
      bit_io(1'b1, 1'b0, 1'b0);
      bit_io(op[1], 1'b0, 1'b0);
      bit_io(op[0], 1'b0, 1'b0);
      for (int i = AW - 1; i > 0; i--) bit_io(a[i], 1'b0, 1'b0);
      bit_io(a[0], (op == 2'b10), 1'b0);
   endtask

   task automatic end_frame();
      sk = 1'b0;
      tick(4);
      cs_to(1'b0);
   endtask

   task automatic cmd00(input logic [5:0] a);
      send_cmd(2'b00, a, 0, 0);
      end_frame();
   endtask

   task automatic read_words(input logic [5:0] a, input int nbits, input bit from_status,
                             input bit lead0, output logic [63:0] cap);
      logic [15:0] w;
      send_cmd(2'b10, a, from_status, lead0);
      cap = '0;
      cap = {cap[62:0], do_out};
      for (int k = 0; k < nbits; k++) begin
         w = mm[(int'(a) + k / 16) % NW];
         bit_io(1'b0, 1'b1, w[15 - (k % 16)]);
         cap = {cap[62:0], do_out};
      end
      end_frame();
   endtask

   task automatic write_frame(input logic [1:0] op, input logic [5:0] a,
                              input logic [15:0] d, input int nbits);
      send_cmd(op, a, 0, 0);
      for (int i = 0; i < nbits; i++) bit_io(d[15 - i], 1'b0, 1'b0);
      sk = 1'b0;
      tick(4);
      chk_en = 0;
      cs = 1'b0;
   endtask

   task automatic wait_prog(input string name, input int exp_cycles, input int raise_at);
      int n;
      int cnt;
      chk_en = 0;
      n = 0;
      while (!busy && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_cycles == 0) begin
         repeat (20) begin
            check({name, " idle"}, 64'(busy), 64'd0);
            @(posedge clk); #1;
         end
         exp_oe = 1'b0; exp_busy = 1'b0; chk_en = 1;
         return;
      end
      check({name, " rise"}, 64'(busy), 64'd1);
      cnt = 0;
      while (busy && cnt < exp_cycles + 10) begin
         cnt++;
         if (raise_at > 0 && cnt == raise_at) cs = 1'b1;
         if (raise_at > 0 && cnt >= raise_at + 3)
            check({name, " hold"}, 64'({do_oe, do_out}), 64'h2);
         @(posedge clk); #1;
      end
      check({name, " cycles"}, 64'(cnt), 64'(exp_cycles));
      if (raise_at > 0) begin
         check({name, " ready"}, 64'({do_oe, do_out}), 64'h3);
         exp_oe = 1'b1; exp_out = 1'b1;
      end else begin
         exp_oe = 1'b0;
      end
      exp_busy = 1'b0;
      chk_en = 1;
   endtask

   initial begin
      logic [63:0] cap;
      int n;
      for (int i = 0; i < NW; i++) mm[i] = 16'h0F00 + 16'(i);
      mm[5] = 16'hA5C3;
      for (int i = 0; i < NW; i++) dut.mem_q[i] <= mm[i];
      mwen = 0;
      tick(3);
      check("reset", 64'({do_oe, do_out, busy}), 64'h0);
      rst = 1'b0;
      tick(2);
      chk_en = 1;

      // Preloaded word, with a leading zero before the start bit.
      read_words(6'd5, 16, 0, 1, cap);
      check("read5 literal", 64'(cap[16:0]), 64'(17'b0_1010_0101_1100_0011));

      // WRITE while disabled is ignored.
      write_frame(2'b01, 6'd3, 16'h1234, 16);
      wait_prog("wr nowen", 0, 0);
      read_words(6'd3, 16, 0, 0, cap);
      check("read3 old", 64'(cap[15:0]), 64'h0F03);

      // Enabled WRITE with cs raised mid-programming, then READ from STATUS.
      cmd00(6'b110000); mwen = 1;
      write_frame(2'b01, 6'd3, 16'h1234, 16);
      wait_prog("wr3", P, P / 2);
      mm[3] = 16'h1234;
      read_words(6'd3, 16, 1, 0, cap);
      check("read3 new", 64'(cap[15:0]), 64'h1234);

      // Address wrap across the top of the array.
      read_words(6'd63, 32, 0, 0, cap);
      check("wrap", 64'(cap[31:0]), 64'h0F3F_0F00);

      // Short WRITE frame, then EWDS and a refused ERASE.
      write_frame(2'b01, 6'd3, 16'hBEEF, 9);
      wait_prog("wr short", 0, 0);
      cmd00(6'b000000); mwen = 0;
      write_frame(2'b11, 6'd3, 16'h0000, 0);
      wait_prog("erase nowen", 0, 0);
      read_words(6'd3, 16, 0, 0, cap);
      check("read3 kept", 64'(cap[15:0]), 64'h1234);

      // Reset in the middle of programming aborts the write.
      cmd00(6'b110000); mwen = 1;
      write_frame(2'b01, 6'd7, 16'h00FF, 16);
      n = 0;
      while (!busy && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort rise", 64'(busy), 64'd1);
      repeat (P / 2) begin @(posedge clk); #1; end
      cs = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      check("abort pre", 64'({busy, do_oe, do_out}), 64'h6);
      rst = 1'b1;
      #1;
      check("abort rst", 64'({busy, do_oe}), 64'h0);
      mwen = 0;
      tick(2);
      cs = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(2);
      exp_oe = 1'b0; exp_busy = 1'b0; chk_en = 1;
      read_words(6'd7, 16, 0, 0, cap);
      check("read7 old", 64'(cap[15:0]), 64'h0F07);

      // ERAL, then read back the whole array.
      cmd00(6'b110000); mwen = 1;
      write_frame(2'b00, 6'b100000, 16'h0000, 0);
      wait_prog("eral", NW * P, 0);
      for (int i = 0; i < NW; i++) mm[i] = 16'hFFFF;
      read_words(6'd0, NW * 16, 0, 0, cap);
      check("eral tail", 64'(cap[47:0]), 64'hFFFF_FFFF_FFFF);

      // WRAL.
      write_frame(2'b00, 6'b010000, 16'h5A5A, 16);
      wait_prog("wral", NW * P, 0);
      for (int i = 0; i < NW; i++) mm[i] = 16'h5A5A;
      read_words(6'd62, 48, 0, 0, cap);
      check("wral", 64'(cap[47:0]), 64'h5A5A_5A5A_5A5A);

      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
